// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART1 line levels, frame width and receiver FSM states
package uart_pkg;

  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP,
    UART_BREAK
  } uart_state_e;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart1_rx_if.sv
// rtl/uart1_rx_if.sv - parallel byte port of the UART1 receiver with valid/ack handshake and error flags
interface uart1_rx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_ack;
  logic                      framing_err;
  logic                      overrun;
  logic                      busy;

  modport master (
    output rx_data,
    output rx_valid,
    output framing_err,
    output overrun,
    output busy,
    input  rx_ack
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  framing_err,
    input  overrun,
    input  busy,
    output rx_ack
  );

endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for an asynchronous single-bit input
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart1_rx.sv
// rtl/uart1_rx.sv - UART1 serial receiver: 8N1 framing, mid-bit sampling, framing and overrun flags
module uart1_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int HALF         = (CLKS_PER_BIT - 1) / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  uart1_rx_if.master rx_bus
);

  localparam int             CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_e               state;
  logic                      line_s;
  logic [2:0]                bit_cnt;
  logic [CNT_W-1:0]          cyc_cnt;
  logic [UART_DATA_BITS-1:0] shift;

  uart_sync2 #(.RST_VAL(UART_IDLE_LVL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (serial_in),
    .q   (line_s)
  );

  // cyc_cnt holds the offset the coming edge will have from the previous sample point
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= UART_IDLE;
      bit_cnt            <= '0;
      cyc_cnt            <= '0;
      shift              <= '0;
      rx_bus.rx_data     <= '0;
      rx_bus.rx_valid    <= 1'b0;
      rx_bus.framing_err <= 1'b0;
      rx_bus.overrun     <= 1'b0;
      rx_bus.busy        <= 1'b0;
    end else begin
      rx_bus.framing_err <= 1'b0;
      if (rx_bus.rx_ack && rx_bus.rx_valid) begin
        rx_bus.rx_valid <= 1'b0;
      end

      case (state)
        UART_IDLE: begin
          if (line_s == UART_START_LVL) begin
            rx_bus.busy <= 1'b1;
            cyc_cnt     <= CNT_ONE;
            bit_cnt     <= '0;
            state       <= (HALF == 0) ? UART_DATA : UART_START;
          end
        end

        UART_START: begin
          if (cyc_cnt == CNT_HALF) begin
            cyc_cnt <= CNT_ONE;
            if (line_s == UART_START_LVL) begin
              state <= UART_DATA;
            end else begin
              state       <= UART_IDLE;
              rx_bus.busy <= 1'b0;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CNT_ONE;
          end
        end

        UART_DATA: begin
          if (cyc_cnt == CNT_BIT) begin
            cyc_cnt <= CNT_ONE;
            shift   <= {line_s, shift[UART_DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) begin
              state <= UART_STOP;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CNT_ONE;
          end
        end

        UART_STOP: begin
          if (cyc_cnt == CNT_BIT) begin
            cyc_cnt <= CNT_ONE;
            if (line_s == UART_STOP_LVL) begin
              // a fresh byte overrides an ack landing on the same edge
              rx_bus.rx_data  <= shift;
              rx_bus.rx_valid <= 1'b1;
              if (rx_bus.rx_valid && !rx_bus.rx_ack) begin
                rx_bus.overrun <= 1'b1;
              end
              state       <= UART_IDLE;
              rx_bus.busy <= 1'b0;
            end else begin
              rx_bus.framing_err <= 1'b1;
              state              <= UART_BREAK;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CNT_ONE;
          end
        end

        UART_BREAK: begin
          if (line_s == UART_IDLE_LVL) begin
            state       <= UART_IDLE;
            rx_bus.busy <= 1'b0;
          end
        end

        default: begin
          state       <= UART_IDLE;
          rx_bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart1_rx.sv
// tb/tb_uart1_rx.sv - self-checking bench for uart1_rx at 1 and 4 clocks per bit
module tb_uart1_rx;

  logic clk;
  logic rst1, rst4;
  logic ser1, ser4;
  int   n_vec = 0;
  int   n_err = 0;
  int   fe_cnt1 = 0;
  int   fe_cnt4 = 0;

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ovr;

  uart1_rx_if bus1 ();
  uart1_rx_if bus4 ();

  uart1_rx #(.CLKS_PER_BIT(1)) dut1 (
    .clk       (clk),
    .rst       (rst1),
    .serial_in (ser1),
    .rx_bus    (bus1)
  );

  uart1_rx #(.CLKS_PER_BIT(4)) dut4 (
    .clk       (clk),
    .rst       (rst4),
    .serial_in (ser4),
    .rx_bus    (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus1.framing_err === 1'b1) fe_cnt1 <= fe_cnt1 + 1;
    if (bus4.framing_err === 1'b1) fe_cnt4 <= fe_cnt4 + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // Reference model of the byte port: what a consumer sees after each whole frame
  task automatic m_reset();
    m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic m_frame(input logic [7:0] b, input logic stop_ok, input logic ack_same_edge);
    if (stop_ok) begin
      if (m_valid && !ack_same_edge) m_ovr = 1'b1;
      m_data  = b;
      m_valid = 1'b1;
    end
  endtask

  task automatic m_ack();
    m_valid = 1'b0;
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 1) ser1 = v;
    else          ser4 = v;
  endtask

  // Drives start, 8 data bits LSB first and stop; returns #1 after the last stop-bit edge
  task automatic send_frame(input int sel, input logic [7:0] b, input logic stop);
    int   c;
    logic v;
    c = (sel == 1) ? 1 : 4;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      v = 1'b0;
      else if (i == 9) v = stop;
      else             v = b[i-1];
      set_line(sel, v);
      repeat (c) @(posedge clk);
      #1;
    end
    set_line(sel, 1'b1);
  endtask

  task automatic pulse_reset1();
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    m_reset();
  endtask

  task automatic ack1();
    bus1.rx_ack = 1'b1;
    @(posedge clk); #1;
    bus1.rx_ack = 1'b0;
    m_ack();
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst4 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0; rst4 = 1'b0;
    m_reset();
    n_vec++; if (bus1.rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data1: got %h expected 00", bus1.rx_data); end
    n_vec++; if ({bus1.rx_valid, bus1.framing_err, bus1.overrun, bus1.busy} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags1: got %b expected 0000", {bus1.rx_valid, bus1.framing_err, bus1.overrun, bus1.busy}); end
    n_vec++; if ({bus4.rx_data, bus4.rx_valid, bus4.framing_err, bus4.overrun, bus4.busy} !== 12'h000) begin
      n_err++; $display("FAIL reset_all4: got %h expected 000", {bus4.rx_data, bus4.rx_valid, bus4.framing_err, bus4.overrun, bus4.busy}); end
  endtask

  task automatic test_single_frame();
    send_frame(1, 8'hA4, 1'b1);
    @(posedge clk); #1;
    n_vec++; if (bus1.rx_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %b expected 0", bus1.rx_valid); end
    @(posedge clk); #1;
    m_frame(8'hA4, 1'b1, 1'b0);
    n_vec++; if (bus1.rx_data !== m_data) begin n_err++; $display("FAIL single_data: got %h expected %h", bus1.rx_data, m_data); end
    n_vec++; if (bus1.rx_valid !== m_valid) begin n_err++; $display("FAIL single_valid: got %b expected %b", bus1.rx_valid, m_valid); end
    n_vec++; if (bus1.framing_err !== 1'b0) begin n_err++; $display("FAIL single_ferr: got %b expected 0", bus1.framing_err); end
    ack1();
    n_vec++; if (bus1.rx_valid !== m_valid) begin n_err++; $display("FAIL single_ack: got %b expected %b", bus1.rx_valid, m_valid); end
  endtask

  task automatic test_framing();
    int fe0;
    fe0 = fe_cnt1;
    send_frame(1, 8'h3C, 1'b0);
    ser1 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_vec++; if (fe_cnt1 - fe0 !== 1) begin n_err++; $display("FAIL frame_pulse_cycles: got %0d expected 1", fe_cnt1 - fe0); end
    n_vec++; if (bus1.busy !== 1'b1) begin n_err++; $display("FAIL frame_break_busy: got %b expected 1", bus1.busy); end
    n_vec++; if ({bus1.rx_data, bus1.rx_valid} !== {m_data, m_valid}) begin
      n_err++; $display("FAIL frame_unchanged: got %h/%b expected %h/%b", bus1.rx_data, bus1.rx_valid, m_data, m_valid); end
    ser1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (bus1.busy !== 1'b0) begin n_err++; $display("FAIL frame_break_exit: got %b expected 0", bus1.busy); end
    send_frame(1, 8'h55, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    m_frame(8'h55, 1'b1, 1'b0);
    n_vec++; if ({bus1.rx_data, bus1.rx_valid} !== {m_data, m_valid}) begin
      n_err++; $display("FAIL frame_recover: got %h/%b expected %h/%b", bus1.rx_data, bus1.rx_valid, m_data, m_valid); end
  endtask

  task automatic test_back_to_back();
    pulse_reset1();
    send_frame(1, 8'h12, 1'b1);
    send_frame(1, 8'h34, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    m_frame(8'h12, 1'b1, 1'b0);
    m_frame(8'h34, 1'b1, 1'b0);
    n_vec++; if ({bus1.rx_data, bus1.rx_valid, bus1.overrun} !== {m_data, m_valid, m_ovr}) begin
      n_err++; $display("FAIL b2b_overrun: got %h/%b/%b expected %h/%b/%b", bus1.rx_data, bus1.rx_valid, bus1.overrun, m_data, m_valid, m_ovr); end
    pulse_reset1();
    send_frame(1, 8'h12, 1'b1);
    send_frame(1, 8'h34, 1'b1);
    @(posedge clk); #1;
    bus1.rx_ack = 1'b1;
    @(posedge clk); #1;
    bus1.rx_ack = 1'b0;
    m_frame(8'h12, 1'b1, 1'b0);
    m_frame(8'h34, 1'b1, 1'b1);
    n_vec++; if ({bus1.rx_data, bus1.rx_valid, bus1.overrun} !== {m_data, m_valid, m_ovr}) begin
      n_err++; $display("FAIL b2b_ack_wins: got %h/%b/%b expected %h/%b/%b", bus1.rx_data, bus1.rx_valid, bus1.overrun, m_data, m_valid, m_ovr); end
  endtask

  task automatic test_random_frames();
    logic [7:0] b;
    logic       ok;
    int         fe0, bad;
    fe0 = fe_cnt1;
    bad = 0;
    for (int n = 0; n < 16; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send_frame(1, b, ok);
      repeat (ok ? 2 : 3) @(posedge clk);
      #1;
      m_frame(b, ok, 1'b0);
      if (!ok) bad++;
      n_vec++; if ({bus1.rx_data, bus1.rx_valid, bus1.overrun, bus1.busy} !== {m_data, m_valid, m_ovr, 1'b0}) begin
        n_err++; $display("FAIL rand_frame%0d: got %h/%b/%b/%b expected %h/%b/%b/0", n,
                          bus1.rx_data, bus1.rx_valid, bus1.overrun, bus1.busy, m_data, m_valid, m_ovr); end
      if ($urandom_range(0, 1) == 1) begin
        ack1();
        n_vec++; if (bus1.rx_valid !== m_valid) begin n_err++; $display("FAIL rand_ack%0d: got %b expected %b", n, bus1.rx_valid, m_valid); end
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    n_vec++; if (fe_cnt1 - fe0 !== bad) begin n_err++; $display("FAIL rand_ferr_count: got %0d expected %0d", fe_cnt1 - fe0, bad); end
  endtask

  task automatic test_reset_midframe();
    ser1 = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      ser1 = 1'b1;
      @(posedge clk); #1;
    end
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    m_reset();
    n_vec++; if ({bus1.rx_data, bus1.rx_valid, bus1.framing_err, bus1.overrun, bus1.busy} !== 12'h000) begin
      n_err++; $display("FAIL mid_reset: got %h expected 000", {bus1.rx_data, bus1.rx_valid, bus1.framing_err, bus1.overrun, bus1.busy}); end
    repeat (7) @(posedge clk);
    #1;
    n_vec++; if ({bus1.rx_valid, bus1.busy} !== 2'b00) begin
      n_err++; $display("FAIL mid_no_partial: got %b expected 00", {bus1.rx_valid, bus1.busy}); end
    send_frame(1, 8'h81, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    m_frame(8'h81, 1'b1, 1'b0);
    n_vec++; if ({bus1.rx_data, bus1.rx_valid, bus1.overrun} !== {m_data, m_valid, m_ovr}) begin
      n_err++; $display("FAIL mid_next_frame: got %h/%b/%b expected %h/%b/%b", bus1.rx_data, bus1.rx_valid, bus1.overrun, m_data, m_valid, m_ovr); end
  endtask

  task automatic test_oversampled();
    int         busy_cycles;
    int         fe0;
    logic [7:0] b;
    fe0 = fe_cnt4;
    ser4 = 1'b0;
    @(posedge clk); #1;
    ser4 = 1'b1;
    busy_cycles = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus4.busy === 1'b1) busy_cycles++;
    end
    n_vec++; if (busy_cycles !== 1) begin n_err++; $display("FAIL glitch_busy_cycles: got %0d expected 1", busy_cycles); end
    n_vec++; if ({bus4.rx_data, bus4.rx_valid, bus4.overrun} !== 10'h000 || fe_cnt4 != fe0) begin
      n_err++; $display("FAIL glitch_outputs: got %h/%b/%b ferr %0d expected 00/0/0 ferr 0",
                        bus4.rx_data, bus4.rx_valid, bus4.overrun, fe_cnt4 - fe0); end
    // start edge k; stop sample lands on edge k+39, the last edge of the stop bit
    b = 8'hA4;
    for (int i = 0; i < 9; i++) begin
      ser4 = (i == 0) ? 1'b0 : b[i-1];
      repeat (4) @(posedge clk);
      #1;
    end
    ser4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (bus4.rx_valid !== 1'b0) begin n_err++; $display("FAIL os_early_valid: got %b expected 0", bus4.rx_valid); end
    @(posedge clk); #1;
    n_vec++; if ({bus4.rx_data, bus4.rx_valid, bus4.framing_err} !== {8'hA4, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL os_frame: got %h/%b/%b expected a4/1/0", bus4.rx_data, bus4.rx_valid, bus4.framing_err); end
  endtask

  initial begin
    ser1 = 1'b1; ser4 = 1'b1;
    rst1 = 1'b1; rst4 = 1'b1;
    bus1.rx_ack = 1'b0;
    bus4.rx_ack = 1'b0;
    m_reset();
    test_reset();
    test_single_frame();
    test_framing();
    test_back_to_back();
    test_random_frames();
    test_reset_midframe();
    test_oversampled();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart1_rx.md
# uart1_rx

Serial receiver for the UART1 link. It consumes the single-wire `serial_out` stream produced by the UART1 transmitter: idle high, one start bit (low), 8 data bits, one stop bit (high). It recovers each byte and presents it on a parallel port with a valid/ack handshake. It also flags framing and overrun errors for the downstream consumer.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 1: clock cycles per serial bit; must be ≥1.
- `HALF`, default `(CLKS_PER_BIT-1)/2`: sample offset within a bit; derived, do not override.

Ports:
- `clk` in 1: single system clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `serial_in` in 1: line from the transmitter's `serial_out`; asynchronous to `clk`.
- `rx_ack` in 1: consumer accepts `rx_data`; clears `rx_valid`.
- `rx_data` out 8: last correctly framed byte.
- `rx_valid` out 1: `rx_data` holds an unacknowledged byte.
- `framing_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `overrun` out 1: sticky; a byte completed while `rx_valid` was already high.
- `busy` out 1: high in every state except IDLE.

## Operation
- `serial_in` passes through a 2-flop synchronizer (`line_s`), which resets to 1.
- FSM states are IDLE, START, DATA, STOP and BREAK. A bit counter (3 bits) and a cycle counter (`$clog2(CLKS_PER_BIT+1)` bits) support it.
- **IDLE:** when `line_s`=0, this is the start bit at offset 0.
  - If HALF=0, this edge is the start sample: go to DATA.
  - Otherwise go to START.
- **START:** at offset HALF, sample `line_s`.
  - If 0, go to DATA.
  - If 1 (glitch), go to IDLE with no flags raised.
- **DATA:** samples are taken exactly CLKS_PER_BIT cycles after the previous sample.
  - Bits are LSB first into a shift register.
  - After the 8th sample, go to STOP.
- **STOP:** sample CLKS_PER_BIT cycles after the 8th data sample.
  - **Stop bit 1:**
    - `rx_data` ← shift register and `rx_valid` ← 1.
    - If `rx_valid` was already 1 and `rx_ack` is not asserted that edge, set `overrun` and still overwrite `rx_data`.
    - Go to IDLE.
  - **Stop bit 0:** pulse `framing_err`. `rx_data` and `rx_valid` are unchanged. Go to BREAK.
- **BREAK:** wait for `line_s`=1, then go to IDLE. This prevents a held-low line from being decoded as repeated frames.
- **Handshake:**
  - `rx_ack` while `rx_valid`=1 clears `rx_valid` on that edge.
  - If that edge is also a successful stop sample, the new byte wins: `rx_valid` stays 1, `rx_data` updates, and `overrun` is not set.
  - `rx_ack` with `rx_valid`=0 is ignored.
- `overrun` clears only on `rst`.
- The next frame's start bit may immediately follow the stop bit. The stop sample returns the FSM to IDLE in time, so back-to-back frames decode without gaps.

## Timing
- Reset values: `rx_data`=8'h00, `rx_valid`=0, `framing_err`=0, `overrun`=0, `busy`=0, FSM=IDLE, synchronizer flops=1.
- `rst` mid-frame aborts reception on that edge. Nothing is emitted for the partial frame.
- Let the first low value of the start bit on `serial_in` be captured at edge k.
  - The FSM detects it at edge k+2.
  - Data bit i is sampled at edge k+2+HALF+(i+1)·CLKS_PER_BIT.
  - The stop bit is sampled at edge k+2+HALF+9·CLKS_PER_BIT.
- Outputs are registered and become visible after the stop-sample edge. For CLKS_PER_BIT=1 that is edge k+11.
- `busy` rises after edge k+2 and falls after the stop-sample edge (or after the START glitch-reject edge).
- `framing_err` is high for exactly one cycle.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (`UART_IDLE`, `UART_START`, `UART_DATA`, `UART_STOP`, `UART_BREAK`).
  - `UART_DATA_BITS`=8, `UART_IDLE_LVL`=1'b1, `UART_START_LVL`=1'b0, `UART_STOP_LVL`=1'b1.
  - The transmitter reuses this package.
- One sub-module: `uart_sync2`, a 2-flop synchronizer with parameterized reset value (1 here).
- The FSM, counters, shift register and output registers stay in `uart1_rx`.

## Test plan
- **Single frame:** CLKS_PER_BIT=1, `rst` for 1 cycle, then idle high, start 0, bits 0,0,1,0,0,1,0,1, stop 1 → after the stop-sample edge `rx_data`=8'hA4, `rx_valid`=1, `framing_err`=0; `rx_ack` one cycle later → `rx_valid`=0.
- **Framing error:** frame for 8'h3C with stop=0, line held low for 5 more cycles, then high → one-cycle `framing_err`, `rx_valid` stays 0, `rx_data` unchanged, FSM stays in BREAK until the line goes high, then a following 8'h55 frame decodes correctly.
- **Back-to-back and overrun:** frames 8'h12 then 8'h34 with no idle gap and no `rx_ack` → `rx_data`=8'h34, `rx_valid`=1, `overrun`=1; repeat with `rx_ack` on the second stop-sample edge → `overrun`=0.
- **Oversampled glitch:** CLKS_PER_BIT=4, 1-cycle low glitch on idle line → START rejects it, no outputs change, `busy` high for 1 cycle; a full 8'hA4 frame at 4 cycles/bit then gives `rx_data`=8'hA4 at edge k+2+1+36.
- **Reset mid-frame:** assert `rst` during data bit 4 of 8'hFF → all outputs at reset values; the next complete frame 8'h81 decodes normally.
